// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared states and constants for the instruction fetch sequencer
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    KILL  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - handshaked PC/fetch/IR sequencer; FETCH_ALIGN_CHECK_EN adds misaligned-redirect rejection
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [DATA_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [DATA_W-1:0] imem_addr_o,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [DATA_W-1:0] ir_o,
  output logic [DATA_W-1:0] ir_pc_o,
  output logic              ir_valid_o,
  output logic [DATA_W-1:0] pc_plus4_o
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              align_err_o
`endif
);

  localparam logic [DATA_W-1:0] INC = DATA_W'(PC_INC);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              redir_take;
  logic [DATA_W-1:0] redir_target;

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_err_q;
  logic misaligned;

  // A misaligned target is dropped entirely rather than rounded down.
  assign misaligned   = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign redir_take   = redirect_i && !misaligned;
  assign redir_target = redirect_pc_i;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)        align_err_q <= 1'b0;
    else if (misaligned) align_err_q <= 1'b1;
  end

  assign align_err_o = align_err_q;
`else
  assign redir_take   = redirect_i;
  assign redir_target = redirect_pc_i & ~DATA_W'(3);
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        // Redirect beats returning data; a same-cycle response is simply dropped.
        if (redir_take) begin
          pc_d    = redir_target;
          state_d = imem_rvalid_i ? FETCH : KILL;
        end else if (imem_rvalid_i) begin
          ir_d       = imem_rdata_i;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + INC;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (redir_take) begin
          ir_valid_d = 1'b0;
          pc_d       = redir_target;
          state_d    = FETCH;
        end else if (!stall_i) begin
          ir_valid_d = 1'b0;
          state_d    = FETCH;
        end
      end
      KILL: begin
        if (redir_take)    pc_d    = redir_target;
        if (imem_rvalid_i) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= DATA_W'(NOP_WORD);
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign imem_req_o  = (state_q == FETCH);
  assign imem_addr_o = pc_q;
  assign ir_o        = ir_q;
  assign ir_pc_o     = ir_pc_q;
  assign ir_valid_o  = ir_valid_q;
  assign pc_plus4_o  = ir_pc_q + INC;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that sequences instruction fetch: owns the program counter, issues requests to a variable-latency instruction memory, and presents the fetched word to decode as the instruction register.
- Arbitrates between sequential advance (PC+4), control-flow redirect (branch/jump) and decode stall.
- Sits between instruction memory and decode, replacing free-running PC update with a handshaked, stall- and flush-aware fetch.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- DATA_W, 32, instruction and address width.

Ports:
- CLK  in  1  single clock; all state updates on posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- stall_i  in  1  decode cannot accept the presented instruction this cycle.
- redirect_i  in  1  one-cycle pulse: take control-flow change to redirect_pc_i.
- redirect_pc_i  in  32  redirect target byte address.
- imem_req_o  out  1  fetch request; held high until imem_rvalid_i.
- imem_addr_o  out  32  byte address of request (= current PC); stable while imem_req_o high.
- imem_rvalid_i  in  1  one-cycle pulse: imem_rdata_i valid for the outstanding request.
- imem_rdata_i  in  32  returned instruction word.
- ir_o  out  32  instruction register.
- ir_pc_o  out  32  byte address of ir_o.
- ir_valid_o  out  1  ir_o holds an unconsumed instruction.
- pc_plus4_o  out  32  ir_pc_o + 4 (link value for jal-style writes).

Behaviour:
- Reset (async, RESET_N=0): state=IDLE, pc=RESET_PC, ir_o=0, ir_pc_o=0, ir_valid_o=0, imem_req_o=0, imem_addr_o=RESET_PC, pc_plus4_o=4. Reset mid-request abandons it; an imem_rvalid_i seen in IDLE is ignored.
- Handshake rules:
  - Only one outstanding request.
  - Consumer accepts on a cycle with ir_valid_o=1 and stall_i=0.
  - Redirect has priority over stall and over returning data.
- States:
  - IDLE: req=0. Always goes to FETCH next cycle.
  - FETCH: req=1, addr=pc.
    - redirect_i (with or without rvalid): pc<=redirect target. Goes to KILL if no rvalid this cycle; goes to FETCH if rvalid same cycle (data discarded).
    - rvalid only: ir_o<=rdata, ir_pc_o<=pc, ir_valid_o<=1, pc<=pc+4, goes to HOLD.
  - HOLD: req=0, ir outputs stable.
    - redirect_i: ir_valid_o<=0, pc<=redirect target, goes to FETCH.
    - else if stall_i=0: instruction accepted, ir_valid_o<=0, goes to FETCH.
    - else: stays in HOLD.
  - KILL: req=0, waits for the stale response.
    - rvalid: data discarded, goes to FETCH.
    - redirect_i in KILL: pc<=new target, stays in KILL (youngest target wins).
- Latency: rvalid at cycle t gives ir_valid_o at t+1. Acceptance at t+1 gives the next request at t+2. Best-case throughput is one instruction per 3 cycles with 1-cycle memory.
- Arithmetic: all PC math is 32-bit modulo. 32'hFFFFFFFC + 4 wraps to 0, with no flag. pc_plus4_o = ir_pc_o + 4, same wrap.
- stall_i is ignored in IDLE, FETCH and KILL. It only holds the HOLD state.
- redirect_i and rvalid arriving together in FETCH: redirect wins and ir is not updated.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - redirect_pc_i[1:0]!=0 is a misaligned target. The redirect is ignored (pc unchanged, no state change from it).
  - Extra output align_err_o (1 bit) is set and held sticky until reset.
- Undefined:
  - redirect_pc_i[1:0] is forced to 2'b00 before use.
  - align_err_o port is absent.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {IDLE, FETCH, HOLD, KILL}
  - PC_INC = 32'd4
  - default RESET_PC
  - NOP word 32'h00000000
- No sub-module is required; the block is a single module containing the PC register, next-PC mux and FSM.

Test Plan:
- Reset release, 1-cycle memory returning 32'h00000020, 32'h8C020004 → requests at 0x0, 0x4; ir_o matches in order; ir_pc_o 0x0 then 0x4; pc_plus4_o 0x4 then 0x8.
- stall_i high 3 cycles while ir_valid_o=1 → ir_o/ir_pc_o constant, imem_req_o=0; next request at 0x8 only after stall_i falls.
- Memory latency 4 cycles, redirect_i to 0x40 at cycle 2 of wait → returned word discarded (ir_valid_o stays 0); next request address 0x40.
- redirect_i (target 0x100) same cycle as imem_rvalid_i → ir not updated; next request 0x100.
- Redirect in HOLD with stall_i=1 → ir_valid_o drops next cycle; fetch from target. Separately, RESET_N asserted mid-wait → all outputs return to reset values immediately.
- FETCH_ALIGN_CHECK_EN: redirect to 0x102 → align_err_o=1 sticky, fetch continues at pc+4. Without the macro, the same redirect fetches 0x100.
